// File: rtl/rat_io_pkg.sv
// Shared definitions for RAT MCU I/O peripherals: port IDs, interrupt FSM
// state encoding and the source-ID width.
package rat_io_pkg;

  localparam logic [7:0] MASK_PORT = 8'hF0;
  localparam logic [7:0] PEND_PORT = 8'hF1;
  localparam logic [7:0] ID_PORT   = 8'hF2;

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

endpackage

// File: rtl/intr_sync_edge.sv
// Per-source two-flop synchroniser followed by a rising-edge detector.
// rise is a one-cycle pulse two clocks after the raw level is first sampled high.
module intr_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      hist_reg <= 1'b0;
    end else begin
      meta_reg <= src;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~hist_reg;

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: edge-detected sources, pending/mask state,
// global enable and the request/acknowledge/service handshake with the CPU.
module intr_ctrl #(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] MASK_PORT = rat_io_pkg::MASK_PORT,
  parameter logic [7:0] PEND_PORT = rat_io_pkg::PEND_PORT,
  parameter logic [7:0] ID_PORT   = rat_io_pkg::ID_PORT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               io_strb,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  output logic [7:0]         in_data,
  output logic               in_hit,
  input  logic               int_en_set,
  input  logic               int_en_clr,
  input  logic               int_ack,
  output logic               interrupt,
  output logic [2:0]         int_id
);

  import rat_io_pkg::*;

  intr_state_t state_reg, state_next;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg, mask_next;
  logic [NUM_SRC-1:0] active;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic               gie_reg, gie_next;
  logic               ack_take;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      intr_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .src   (irq_src[gi]),
        .rise  (rise[gi])
      );
    end
  endgenerate

  assign active   = pending_reg & mask_reg;
  assign win_any  = |active;
  assign ack_take = (state_reg == REQ) && int_ack;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = ID_W'(i);
    end
  end

  // A new edge on the acknowledged source re-pends it: set after clear.
  always_comb begin
    pending_next = pending_reg;
    if (ack_take) pending_next[id_reg] = 1'b0;
    pending_next = pending_next | rise;
  end

  always_comb begin
    mask_next = mask_reg;
    if (io_strb && (port_id == MASK_PORT)) mask_next = out_port[NUM_SRC-1:0];
  end

  always_comb begin
    gie_next = gie_reg;
    if (int_en_clr || ack_take) gie_next = 1'b0;
    else if (int_en_set)        gie_next = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      IDLE: begin
        if (gie_reg && win_any) begin
          id_next    = win_id;
          state_next = REQ;
        end
      end
      REQ: begin
        if (int_ack)                           state_next = SERVICE;
        else if (!gie_reg || !active[id_reg])  state_next = IDLE;
      end
      SERVICE: begin
        if (int_en_set && !int_en_clr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      mask_reg    <= '0;
      gie_reg     <= 1'b0;
      id_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      mask_reg    <= mask_next;
      gie_reg     <= gie_next;
      id_reg      <= id_next;
    end
  end

  assign interrupt = (state_reg == REQ);
  assign int_id    = id_reg;
  assign in_hit    = (port_id == PEND_PORT) || (port_id == ID_PORT);

  always_comb begin
    in_data = '0;
    if (port_id == PEND_PORT)    in_data[NUM_SRC-1:0] = pending_reg;
    else if (port_id == ID_PORT) in_data = {{(8 - ID_W){1'b0}}, id_reg};
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed handshake scenarios followed by
// a randomized run compared against a behavioural reference model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_src = '0;
  logic       io_strb = 1'b0;
  logic [7:0] port_id = '0;
  logic [7:0] out_port = '0;
  logic [7:0] in_data;
  logic       in_hit;
  logic       int_en_set = 1'b0;
  logic       int_en_clr = 1'b0;
  logic       int_ack = 1'b0;
  logic       interrupt;
  logic [2:0] int_id;

  int checks = 0;
  int failures = 0;

  intr_ctrl #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .io_strb    (io_strb),
    .port_id    (port_id),
    .out_port   (out_port),
    .in_data    (in_data),
    .in_hit     (in_hit),
    .int_en_set (int_en_set),
    .int_en_clr (int_en_clr),
    .int_ack    (int_ack),
    .interrupt  (interrupt),
    .int_id     (int_id)
  );

  always #5 clk = ~clk;

  // Reference model: pending is set when the raw input, as seen two edges ago,
  // was high and three edges ago was low; a request is outstanding or a
  // source is in service, never both.
  logic [7:0] m_d1, m_d2, m_d3;
  logic [7:0] m_pend, m_mask;
  logic       m_gie, m_req, m_svc;
  logic [2:0] m_id;

  always @(posedge clk) begin : model
    logic [7:0] pulse;
    logic [7:0] nxt;
    logic       acked;
    int         win;
    if (reset) begin
      m_d1 <= '0; m_d2 <= '0; m_d3 <= '0;
      m_pend <= '0; m_mask <= '0;
      m_gie <= 1'b0; m_req <= 1'b0; m_svc <= 1'b0; m_id <= '0;
    end else begin
      pulse = m_d2 & ~m_d3;
      acked = m_req && int_ack;
      nxt = m_pend;
      if (acked) nxt[m_id] = 1'b0;
      nxt = nxt | pulse;
      win = -1;
      for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
      if (!m_req && !m_svc) begin
        if (m_gie && win >= 0) begin
          m_req <= 1'b1;
          m_id  <= 3'(win);
        end
      end else if (m_req) begin
        if (acked) begin
          m_req <= 1'b0;
          m_svc <= 1'b1;
        end else if (!m_gie || !(m_pend[m_id] && m_mask[m_id])) begin
          m_req <= 1'b0;
        end
      end else if (int_en_set && !int_en_clr) begin
        m_svc <= 1'b0;
      end
      if (int_en_clr || acked) m_gie <= 1'b0;
      else if (int_en_set)     m_gie <= 1'b1;
      if (io_strb && port_id == 8'hF0) m_mask <= out_port;
      m_pend <= nxt;
      m_d3 <= m_d2; m_d2 <= m_d1; m_d1 <= irq_src;
    end
  end

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic write_mask(input logic [7:0] val);
    io_strb = 1'b1; port_id = 8'hF0; out_port = val;
    cyc();
    io_strb = 1'b0; port_id = 8'h00; out_port = 8'h00;
  endtask

  task automatic pulse_set();
    int_en_set = 1'b1; cyc(); int_en_set = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    port_id = 8'hF1;
    #1;
    checks++;
    if (interrupt !== 1'b0 || int_id !== 3'd0 || in_data !== 8'h00 || in_hit !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: interrupt=%b int_id=%0d pend=%h hit=%b, want 0 0 00 1",
               interrupt, int_id, in_data, in_hit);
    end
    port_id = 8'h33;
    #1;
    checks++;
    if (in_data !== 8'h00 || in_hit !== 1'b0) begin
      failures++;
      $display("FAIL unowned_port: in_data=%h hit=%b, want 00 0", in_data, in_hit);
    end
    $display("test_reset done");
  endtask

  task automatic test_latency_and_ack();
    write_mask(8'h04);
    pulse_set();
    port_id = 8'hF1;
    irq_src[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (interrupt !== (k == 4) || in_data !== ((k >= 3) ? 8'h04 : 8'h00)) begin
        failures++;
        $display("FAIL latency cycle %0d: interrupt=%b pend=%h, want %b %h",
                 k, interrupt, in_data, (k == 4), (k >= 3) ? 8'h04 : 8'h00);
      end
    end
    checks++;
    if (int_id !== 3'd2) begin
      failures++;
      $display("FAIL req_id: int_id=%0d, want 2", int_id);
    end
    pulse_ack();
    checks++;
    if (interrupt !== 1'b0 || in_data !== 8'h00) begin
      failures++;
      $display("FAIL after_ack: interrupt=%b pend=%h, want 0 00", interrupt, in_data);
    end
    port_id = 8'hF2;
    #1;
    checks++;
    if (in_data !== 8'h02 || in_hit !== 1'b1) begin
      failures++;
      $display("FAIL service_id: in_data=%h hit=%b, want 02 1", in_data, in_hit);
    end
    pulse_set();
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (interrupt !== 1'b0) begin
        failures++;
        $display("FAIL held_level_repend cycle %0d: interrupt=%b, want 0", k, interrupt);
      end
    end
    $display("test_latency_and_ack done");
  endtask

  task automatic test_priority();
    irq_src = '0;
    cyc(4);
    write_mask(8'hFF);
    irq_src[5] = 1'b1;
    irq_src[1] = 1'b1;
    cyc(4);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 3'd1) begin
      failures++;
      $display("FAIL priority_first: interrupt=%b int_id=%0d, want 1 1", interrupt, int_id);
    end
    pulse_ack();
    pulse_set();
    cyc();
    checks++;
    if (interrupt !== 1'b1 || int_id !== 3'd5) begin
      failures++;
      $display("FAIL priority_second: interrupt=%b int_id=%0d, want 1 5", interrupt, int_id);
    end
    pulse_ack();
    pulse_set();
    $display("test_priority done");
  endtask

  task automatic test_mask_withdraw();
    irq_src = '0;
    cyc(4);
    irq_src[3] = 1'b1;
    cyc(4);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 3'd3) begin
      failures++;
      $display("FAIL withdraw_req: interrupt=%b int_id=%0d, want 1 3", interrupt, int_id);
    end
    write_mask(8'h00);
    port_id = 8'hF1;
    cyc();
    checks++;
    if (interrupt !== 1'b0 || in_data !== 8'h08) begin
      failures++;
      $display("FAIL withdraw_drop: interrupt=%b pend=%h, want 0 08", interrupt, in_data);
    end
    write_mask(8'h08);
    cyc();
    checks++;
    if (interrupt !== 1'b1 || int_id !== 3'd3) begin
      failures++;
      $display("FAIL withdraw_reassert: interrupt=%b int_id=%0d, want 1 3", interrupt, int_id);
    end
    pulse_ack();
    pulse_set();
    $display("test_mask_withdraw done");
  endtask

  task automatic test_ack_collision();
    irq_src = '0;
    write_mask(8'h01);
    cyc(4);
    irq_src[0] = 1'b1;
    cyc(4);
    checks++;
    if (interrupt !== 1'b1 || int_id !== 3'd0) begin
      failures++;
      $display("FAIL collision_req: interrupt=%b int_id=%0d, want 1 0", interrupt, int_id);
    end
    irq_src[0] = 1'b0;
    cyc(3);
    irq_src[0] = 1'b1;
    cyc(2);
    pulse_ack();
    port_id = 8'hF1;
    #1;
    checks++;
    if (interrupt !== 1'b0 || in_data !== 8'h01) begin
      failures++;
      $display("FAIL collision_pend: interrupt=%b pend=%h, want 0 01", interrupt, in_data);
    end
    pulse_set();
    cyc();
    checks++;
    if (interrupt !== 1'b1 || int_id !== 3'd0) begin
      failures++;
      $display("FAIL collision_rereq: interrupt=%b int_id=%0d, want 1 0", interrupt, int_id);
    end
    $display("test_ack_collision done");
  endtask

  task automatic test_reset_in_service();
    pulse_ack();
    write_mask(8'hFF);
    irq_src[4] = 1'b1;
    irq_src[5] = 1'b1;
    cyc(3);
    port_id = 8'hF1;
    #1;
    checks++;
    if (interrupt !== 1'b0 || in_data !== 8'h30) begin
      failures++;
      $display("FAIL service_pend: interrupt=%b pend=%h, want 0 30", interrupt, in_data);
    end
    reset = 1'b1;
    cyc();
    port_id = 8'hF2;
    #1;
    checks++;
    if (interrupt !== 1'b0 || int_id !== 3'd0 || in_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_service: interrupt=%b int_id=%0d id_read=%h, want 0 0 00",
               interrupt, int_id, in_data);
    end
    port_id = 8'hF1;
    #1;
    checks++;
    if (in_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_pend: pend=%h, want 00", in_data);
    end
    reset = 1'b0;
    pulse_set();
    cyc(5);
    checks++;
    if (interrupt !== 1'b0 || in_data !== 8'h31) begin
      failures++;
      $display("FAIL reset_mask_cleared: interrupt=%b pend=%h, want 0 31", interrupt, in_data);
    end
    $display("test_reset_in_service done");
  endtask

  task automatic test_random();
    logic [7:0] exp_data;
    logic [7:0] ids [4];
    ids[0] = 8'hF0; ids[1] = 8'hF1; ids[2] = 8'hF2; ids[3] = 8'h00;
    reset = 1'b1;
    irq_src = '0;
    cyc(2);
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) irq_src[$urandom_range(0, 7)] ^= 1'b1;
      port_id  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ids[$urandom_range(0, 3)];
      io_strb  = ($urandom_range(0, 5) == 0);
      out_port = 8'($urandom);
      int_en_set = ($urandom_range(0, 4) == 0);
      int_en_clr = ($urandom_range(0, 11) == 0);
      int_ack  = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      #1;
      exp_data = (port_id == 8'hF1) ? m_pend : (port_id == 8'hF2) ? {5'b0, m_id} : 8'h00;
      checks++;
      if (interrupt !== m_req || int_id !== m_id || in_data !== exp_data ||
          in_hit !== (port_id == 8'hF1 || port_id == 8'hF2)) begin
        failures++;
        $display("FAIL random cycle %0d: interrupt=%b int_id=%0d in_data=%h hit=%b, want %b %0d %h %b",
                 n, interrupt, int_id, in_data, in_hit, m_req, m_id, exp_data,
                 (port_id == 8'hF1 || port_id == 8'hF2));
      end
      cyc();
    end
    io_strb = 1'b0; int_en_set = 1'b0; int_en_clr = 1'b0; int_ack = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_latency_and_ack();
    test_priority();
    test_mask_withdraw();
    test_ack_collision();
    test_reset_in_service();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
